// File: rtl/two_of_five_serializer_if.sv
// Producer/stream bundle for the 2-of-5 serializer.
//   digit_in    [3:0] BCD digit offered by the producer
//   digit_valid       digit_in holds a digit to transfer
//   digit_ready       serializer can accept a digit this cycle
//   out               serial 2-of-5 stream, one bit per cycle
//   sof               out carries bit 0 of a nibble
//   level       [2:0] digits queued in the FIFO
//   err               (TOF_ERR_FLAG_EN only) one-cycle pulse after a non-BCD transfer
// Modports: master = producer/consumer side, slave = serializer.
interface two_of_five_serializer_if;
  logic [3:0] digit_in;
  logic       digit_valid;
  logic       digit_ready;
  logic       out;
  logic       sof;
  logic [2:0] level;
`ifdef TOF_ERR_FLAG_EN
  logic       err;

  modport master (output digit_in, digit_valid,
                  input  digit_ready, out, sof, level, err);
  modport slave  (input  digit_in, digit_valid,
                  output digit_ready, out, sof, level, err);
`else
  modport master (output digit_in, digit_valid,
                  input  digit_ready, out, sof, level);
  modport slave  (input  digit_in, digit_valid,
                  output digit_ready, out, sof, level);
`endif
endinterface

// File: rtl/two_of_five_serializer.sv
// BCD to 2-of-5 serializer with a 4-entry digit FIFO.
// A free-running 5-phase counter frames the output stream; on phase 4 the
// next frame is loaded from the FIFO head, or an idle 00000 frame if empty.
// Ports:
//   clk      clock, rising edge
//   reset_l  asynchronous active-low reset
//   bus      two_of_five_serializer_if.slave (digit handshake, out/sof/level)
// Optional macro TOF_ERR_FLAG_EN adds bus.err: one-cycle pulse after each
// transfer of a digit in 10..15.
module two_of_five_serializer (
  input  logic                            clk,
  input  logic                            reset_l,
  two_of_five_serializer_if.slave         bus
);

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned PTR_W   = 2;
  localparam int unsigned LVL_W   = 3;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned FRAME_W = 5;

  // Bit counter expressed as the framing FSM; encoding equals the bit index.
  typedef enum logic [2:0] {
    PH0 = 3'd0,
    PH1 = 3'd1,
    PH2 = 3'd2,
    PH3 = 3'd3,
    PH4 = 3'd4
  } phase_e;

  phase_e               state_q, state_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [DIGIT_W-1:0]   fifo_q [DEPTH];
  logic [DIGIT_W-1:0]   fifo_d [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic                 push_c;
  logic                 pop_c;

  function automatic logic [FRAME_W-1:0] encode(input logic [DIGIT_W-1:0] d);
    case (d)
      4'd0:    encode = 5'b00011;
      4'd1:    encode = 5'b00101;
      4'd2:    encode = 5'b00110;
      4'd3:    encode = 5'b01010;
      4'd4:    encode = 5'b01100;
      4'd5:    encode = 5'b01001;
      4'd6:    encode = 5'b11000;
      4'd7:    encode = 5'b10100;
      4'd8:    encode = 5'b10010;
      4'd9:    encode = 5'b10001;
      default: encode = 5'b00000;
    endcase
  endfunction

  // Ready depends only on registered level, so a full FIFO never passes through.
  assign bus.digit_ready = (level_q != LVL_W'(DEPTH));
  assign bus.out         = frame_q[state_q];
  assign bus.sof         = (state_q == PH0);
  assign bus.level       = level_q;

  assign push_c = bus.digit_valid && bus.digit_ready;
  // Pop decision uses pre-push level: a digit arriving on the load edge waits a frame.
  assign pop_c  = (state_q == PH4) && (level_q != '0);

  // Next-state: phase advance, frame load, FIFO bookkeeping.
  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    case (state_q)
      PH0:     state_d = PH1;
      PH1:     state_d = PH2;
      PH2:     state_d = PH3;
      PH3:     state_d = PH4;
      PH4: begin
        state_d = PH0;
        frame_d = pop_c ? encode(fifo_q[rd_ptr_q]) : '0;
      end
      default: state_d = PH0;
    endcase

    if (push_c) begin
      fifo_d[wr_ptr_q] = bus.digit_in;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    level_d = level_q + LVL_W'(push_c) - LVL_W'(pop_c);
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q  <= PH0;
      frame_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= fifo_d[i];
    end
  end

`ifdef TOF_ERR_FLAG_EN
  logic err_q, err_d;

  // Flags a transferred non-BCD digit one cycle after the transfer edge.
  always_comb begin
    err_d = push_c && (bus.digit_in > DIGIT_W'(9));
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign bus.err = err_q;
`endif

endmodule

// File: tb/tb_two_of_five_serializer.sv
// Self-checking bench for two_of_five_serializer: directed scenarios plus a
// random phase, compared each cycle against a queue-based stream model.
module tb_two_of_five_serializer;

  logic clk;
  logic reset_l;
  two_of_five_serializer_if bus ();

  two_of_five_serializer dut (
    .clk     (clk),
    .reset_l (reset_l),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: cycle number since reset, digit queue, frame being sent.
  int         cyc;
  int         mq[$];
  bit [4:0]   mframe;
  bit         merr;
  bit         last_xfer;
  int         passed;
  int         total;

  function automatic bit [4:0] ref_code(input int d);
    bit [4:0] tbl [10];
    tbl = '{5'b00011, 5'b00101, 5'b00110, 5'b01010, 5'b01100,
            5'b01001, 5'b11000, 5'b10100, 5'b10010, 5'b10001};
    if (d > 9) return 5'b00000;
    return tbl[d];
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic check_outputs();
    int ph;
    ph = cyc % 5;
    chk("out",   8'(bus.out),         8'(mframe[ph]));
    chk("sof",   8'(bus.sof),         8'(ph == 0));
    chk("level", 8'(bus.level),       8'(mq.size()));
    chk("ready", 8'(bus.digit_ready), 8'(mq.size() != 4));
`ifdef TOF_ERR_FLAG_EN
    chk("err",   8'(bus.err),         8'(merr));
`endif
  endtask

  // One clock: drive, check at negedge, update model at the rising edge.
  task automatic cycle(input bit v, input logic [3:0] d);
    bit xfer;
    bus.digit_valid = v;
    bus.digit_in    = d;
    @(negedge clk);
    check_outputs();
    xfer = v && (mq.size() != 4);
    @(posedge clk);
    if (cyc % 5 == 4) begin
      if (mq.size() > 0) mframe = ref_code(mq.pop_front());
      else               mframe = 5'b00000;
    end
    if (xfer) mq.push_back(int'(d));
    merr      = xfer && (d > 4'd9);
    last_xfer = xfer;
    cyc++;
    #1;
    bus.digit_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'd0);
  endtask

  task automatic idle_until(input int ph);
    for (int i = 0; i < 5 && (cyc % 5) != ph; i++) cycle(1'b0, 4'd0);
  endtask

  // Hold a digit valid until it transfers, with a bounded wait.
  task automatic push_digit(input logic [3:0] d);
    int n;
    n = 0;
    last_xfer = 1'b0;
    while (!last_xfer && n < 20) begin
      cycle(1'b1, d);
      n++;
    end
    chk("push_accepted", 8'(last_xfer), 8'd1);
  endtask

  task automatic model_reset();
    cyc    = 0;
    mq.delete();
    mframe = 5'b00000;
    merr   = 1'b0;
  endtask

  task automatic check_reset_values();
    chk("rst_out",   8'(bus.out),         8'd0);
    chk("rst_sof",   8'(bus.sof),         8'd1);
    chk("rst_level", 8'(bus.level),       8'd0);
    chk("rst_ready", 8'(bus.digit_ready), 8'd1);
`ifdef TOF_ERR_FLAG_EN
    chk("rst_err",   8'(bus.err),         8'd0);
`endif
  endtask

  initial begin
    passed = 0;
    total  = 0;
    bus.digit_valid = 1'b0;
    bus.digit_in    = 4'd0;
    reset_l = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    reset_l = 1'b1;

    // Idle stream: all zeros, sof every fifth cycle.
    idle(15);

    // Single digit 7 pushed on phase 2.
    idle_until(2);
    cycle(1'b1, 4'd7);
    idle(10);

    // Back-to-back burst that fills the FIFO and stalls the producer.
    push_digit(4'd0);
    push_digit(4'd9);
    push_digit(4'd3);
    push_digit(4'd5);
    push_digit(4'd2);
    idle(30);

    // Push coinciding with a frame load at level 2.
    idle_until(0);
    cycle(1'b1, 4'd1);
    cycle(1'b1, 4'd8);
    idle_until(4);
    chk("pre_same_edge_level", 8'(mq.size()), 8'd2);
    cycle(1'b1, 4'd6);
    chk("same_edge_level", 8'(bus.level), 8'd2);
    idle(20);

    // Push into empty FIFO on the load edge, then a non-BCD digit.
    idle_until(4);
    cycle(1'b1, 4'd4);
    idle(3);
    push_digit(4'd12);
    idle(15);

    // Reset mid-frame at phase 3 with three digits queued.
    idle_until(0);
    cycle(1'b1, 4'd3);
    cycle(1'b1, 4'd6);
    cycle(1'b1, 4'd9);
    chk("pre_reset_phase", 8'(cyc % 5), 8'd3);
    chk("pre_reset_level", 8'(bus.level), 8'd3);
    reset_l = 1'b0;
    #1;
    check_reset_values();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    model_reset();
    reset_l = 1'b1;
    idle(10);

    // Random traffic with random digits including 10..15.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 99) < 45), 4'($urandom_range(0, 15)));
    end
    idle(25);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/two_of_five_serializer.md
TWO_OF_FIVE_SERIALIZER -- requirements
Module: two_of_five_serializer

Interface
REQ-001 The block SHALL use clock clk (input, 1 bit); all state changes on its rising edge.
REQ-002 The block SHALL use reset reset_l (input, 1 bit), asynchronous, active-low.
REQ-003 digit_in  input  4  BCD digit offered by the producer.
REQ-004 digit_valid  input  1  digit_in holds a digit to transfer.
REQ-005 digit_ready  output  1  block can accept a digit this cycle (FIFO not full).
REQ-006 out  output  1  serial 2-of-5 bit stream, one bit per cycle, feeds the nibble checker "in".
REQ-007 sof  output  1  high when out carries bit 0 (right-hand, first) of a nibble.
REQ-008 level  output  3  number of digits queued in the FIFO (0..4).

Function
REQ-009 Encoding SHALL be: 0=00011, 1=00101, 2=00110, 3=01010, 4=01100, 5=01001, 6=11000, 7=10100, 8=10010, 9=10001; digits 10-15 SHALL encode as 00000.
REQ-010 The block SHALL contain a 4-entry digit FIFO; a transfer occurs on an edge where digit_valid and digit_ready are both high.
REQ-011 digit_ready SHALL equal (level != 4), combinational from registered state only; no full-FIFO pass-through.
REQ-012 A 3-bit bit counter SHALL count 0,1,2,3,4,0,... every cycle from reset, never stalling; sof = (counter == 0).
REQ-013 out SHALL equal bit[counter] of the current 5-bit frame register (bit 0 transmitted first).
REQ-014 On the edge where counter == 4, the frame register SHALL load the encoding of the FIFO head and pop it if level > 0, else load the idle frame 00000.
REQ-015 The stream SHALL never break framing: idle frames fill gaps so the checker sees contiguous 5-bit nibbles.
REQ-016 Push and pop on the same edge SHALL leave level unchanged and preserve order.
REQ-017 A digit pushed on the counter==4 edge into an empty FIFO SHALL NOT be loaded that edge; it goes out in the following frame.
REQ-018 Minimum latency from transfer edge to its sof cycle is 1 cycle (pushed at counter==3, non-empty-free FIFO); maximum with empty FIFO is 5 cycles.
REQ-019 FIFO pointers SHALL be 2-bit wrap-around; level SHALL never exceed 4 or underflow below 0.

Reset
REQ-020 While reset_l is low: counter=0, frame=00000, FIFO empty, level=0, digit_ready=1, out=0, sof=1.
REQ-021 Reset asserted mid-frame SHALL discard the partial frame and all queued digits; first frame after release is idle 00000.
REQ-022 After release, counter advances on the first rising clk edge.

Configuration
REQ-023 Macro TOF_ERR_FLAG_EN: when defined, an output port err (1 bit) SHALL exist and pulse high for exactly one cycle after each edge that transfers a digit of value 10-15; reset value 0.
REQ-024 Without TOF_ERR_FLAG_EN the err port SHALL not exist; digits 10-15 are still accepted and sent as 00000 per REQ-009.

Verification
REQ-025 Reset, no digits for 15 cycles -> out=0 every cycle, sof high at cycles 0,5,10, level=0.
REQ-026 Push 7 at counter==2 -> next frame out sequence 0,0,1,0,1 (10100 LSB first), sof on its first bit, level back to 0.
REQ-027 Push 0,9,3,5,2 back-to-back from reset -> digit_ready low once level=4, fifth push held until a pop; frames 00011,10001,01010,01001,00110 in order, no idle gaps.
REQ-028 Push and frame-load on same edge with level=2 -> level stays 2, order intact.
REQ-029 Push 12 -> frame 00000 transmitted; with TOF_ERR_FLAG_EN err pulses one cycle after the transfer edge.
REQ-030 Assert reset_l low at counter==3 with level=3 -> all outputs at reset values; after release first frame is 00000.
